// File: rtl/data_latch_ctrl_if.sv
// Bus bundle for data_latch_ctrl: CPU-side internal bus / ALU result,
// request handshake and external memory bus pins.
interface data_latch_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             bus_disable;
    logic             res_to_dl;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] dl_in;
    logic             rd_req;
    logic             wr_req;
    logic [WIDTH-1:0] ext_din;
    logic             ext_ready;
    logic [WIDTH-1:0] ext_dout;
    logic             ext_oe;
    logic             ext_rd;
    logic             ext_wr;
    logic [WIDTH-1:0] dl_out;
    logic             busy;
    logic             done;

    // Core / memory side that drives requests and observes the latch
    modport master (
        output bus_disable, res_to_dl, res, dl_in, rd_req, wr_req, ext_din, ext_ready,
        input  ext_dout, ext_oe, ext_rd, ext_wr, dl_out, busy, done
    );

    // The latch controller itself
    modport slave (
        input  bus_disable, res_to_dl, res, dl_in, rd_req, wr_req, ext_din, ext_ready,
        output ext_dout, ext_oe, ext_rd, ext_wr, dl_out, busy, done
    );
endinterface

// File: rtl/data_latch_ctrl.sv
// Data latch between the internal data bus (DL) and the external data bus.
// Runs sequenced external read/write cycles (setup, strobe with wait states
// and ready, hold) and keeps the last read/write data like a bus keeper.
module data_latch_ctrl #(
    parameter int               WIDTH       = 8,
    parameter int               WAIT_CYCLES = 0,
    parameter logic [WIDTH-1:0] KEEP_INIT   = '1
) (
    input  logic              CLK,
    input  logic              nRESET,
    data_latch_ctrl_if.slave  bus
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gBadWait
        $error("data_latch_ctrl: WAIT_CYCLES must be within 0..15");
    end

    localparam logic [3:0] WaitLimit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_e;

    state_e           state_q,   state_d;
    logic             isWrite_q, isWrite_d;
    logic [3:0]       cnt_q,     cnt_d;
    logic [WIDTH-1:0] rdLatch_q, rdLatch_d;
    logic [WIDTH-1:0] wrLatch_q, wrLatch_d;

    logic             oeRaw;
    logic             rdRaw;
    logic             wrRaw;
    logic             doneRaw;
    logic [WIDTH-1:0] dlBase;

    // State and latch registers; reset returns latches to the precharged value
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= IDLE;
            isWrite_q <= 1'b0;
            cnt_q     <= 4'd0;
            rdLatch_q <= KEEP_INIT;
            wrLatch_q <= KEEP_INIT;
        end else begin
            state_q   <= state_d;
            isWrite_q <= isWrite_d;
            cnt_q     <= cnt_d;
            rdLatch_q <= rdLatch_d;
            wrLatch_q <= wrLatch_d;
        end
    end

    // Next-state logic; everything freezes while the bus is released
    always_comb begin
        state_d   = state_q;
        isWrite_d = isWrite_q;
        cnt_d     = cnt_q;
        rdLatch_d = rdLatch_q;
        wrLatch_d = wrLatch_q;
        if (!bus.bus_disable) begin
            case (state_q)
                IDLE: begin
                    if (bus.wr_req) begin
                        isWrite_d = 1'b1;
                        wrLatch_d = bus.dl_in;
                        state_d   = SETUP;
                    end else if (bus.rd_req) begin
                        isWrite_d = 1'b0;
                        state_d   = SETUP;
                    end
                end
                SETUP: begin
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end
                ACCESS: begin
                    if (cnt_q < WaitLimit) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (bus.ext_ready) begin
                        state_d = HOLD;
                        if (!isWrite_q) begin
                            rdLatch_d = bus.ext_din;
                        end
                    end
                end
                HOLD: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Moore strobe decode from the state, then gated off while the bus is released
    always_comb begin
        oeRaw   = 1'b0;
        rdRaw   = 1'b0;
        wrRaw   = 1'b0;
        doneRaw = 1'b0;
        case (state_q)
            SETUP: begin
                oeRaw = isWrite_q;
            end
            ACCESS: begin
                oeRaw = isWrite_q;
                rdRaw = !isWrite_q;
                wrRaw = isWrite_q;
            end
            HOLD: begin
                oeRaw   = isWrite_q;
                doneRaw = 1'b1;
            end
            default: begin
                oeRaw = 1'b0;
            end
        endcase
    end

    assign bus.ext_oe   = oeRaw   & !bus.bus_disable;
    assign bus.ext_rd   = rdRaw   & !bus.bus_disable;
    assign bus.ext_wr   = wrRaw   & !bus.bus_disable;
    assign bus.done     = doneRaw & !bus.bus_disable;
    assign bus.busy     = (state_q != IDLE);
    assign bus.ext_dout = wrLatch_q;

    // Open-drain style merge: a released bus floats high, any zero bit pulls down
    assign dlBase     = bus.bus_disable ? {WIDTH{1'b1}} : rdLatch_q;
    assign bus.dl_out = bus.res_to_dl ? (dlBase & bus.res) : dlBase;

endmodule

// File: tb/tb_data_latch_ctrl.sv
// Self-checking bench for data_latch_ctrl. Two instances (WAIT_CYCLES 0 and 2)
// share one stimulus stream; each is compared every cycle against a
// transaction-level model that counts cycles spent in each bus phase.
module tb_data_latch_ctrl;

    localparam int W     = 8;
    localparam int WAIT0 = 0;
    localparam int WAIT1 = 2;

    logic         clk = 1'b0;
    logic         rstN;
    logic         busDisable, resToDl, rdReq, wrReq, extReady;
    logic [W-1:0] res, dlIn, extDin;

    logic [W-1:0] dout  [2];
    logic [W-1:0] dlOut [2];
    logic         oe    [2];
    logic         rd    [2];
    logic         wr    [2];
    logic         busy  [2];
    logic         done  [2];

    int checks = 0;
    int errors = 0;

    // model: a transaction is either absent, in its setup cycle (age 0),
    // in access (age = access cycles entered so far), or in its hold cycle
    bit           mActive  [2];
    bit           mWr      [2];
    bit           mHold    [2];
    int           mAge     [2];
    logic [W-1:0] mRd      [2];
    logic [W-1:0] mWrLatch [2];

    int cntOe[2], cntRd[2], cntWr[2], cntDone[2], doneAt[2];
    int tickIdx;

    data_latch_ctrl_if #(.WIDTH(W)) bus0 ();
    data_latch_ctrl_if #(.WIDTH(W)) bus1 ();

    assign bus0.bus_disable = busDisable;
    assign bus0.res_to_dl   = resToDl;
    assign bus0.res         = res;
    assign bus0.dl_in       = dlIn;
    assign bus0.rd_req      = rdReq;
    assign bus0.wr_req      = wrReq;
    assign bus0.ext_din     = extDin;
    assign bus0.ext_ready   = extReady;
    assign bus1.bus_disable = busDisable;
    assign bus1.res_to_dl   = resToDl;
    assign bus1.res         = res;
    assign bus1.dl_in       = dlIn;
    assign bus1.rd_req      = rdReq;
    assign bus1.wr_req      = wrReq;
    assign bus1.ext_din     = extDin;
    assign bus1.ext_ready   = extReady;

    assign dout[0]  = bus0.ext_dout;
    assign dlOut[0] = bus0.dl_out;
    assign oe[0]    = bus0.ext_oe;
    assign rd[0]    = bus0.ext_rd;
    assign wr[0]    = bus0.ext_wr;
    assign busy[0]  = bus0.busy;
    assign done[0]  = bus0.done;
    assign dout[1]  = bus1.ext_dout;
    assign dlOut[1] = bus1.dl_out;
    assign oe[1]    = bus1.ext_oe;
    assign rd[1]    = bus1.ext_rd;
    assign wr[1]    = bus1.ext_wr;
    assign busy[1]  = bus1.busy;
    assign done[1]  = bus1.done;

    data_latch_ctrl #(.WIDTH(W), .WAIT_CYCLES(WAIT0), .KEEP_INIT('1)) dut0 (
        .CLK    (clk),
        .nRESET (rstN),
        .bus    (bus0)
    );

    data_latch_ctrl #(.WIDTH(W), .WAIT_CYCLES(WAIT1), .KEEP_INIT('1)) dut1 (
        .CLK    (clk),
        .nRESET (rstN),
        .bus    (bus1)
    );

    always #5 clk = ~clk;

    function automatic int waitOf(input int i);
        return (i == 0) ? WAIT0 : WAIT1;
    endfunction

    // single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic dis, input logic rtd, input logic [W-1:0] r,
                                 input logic [W-1:0] d, input logic rq, input logic wq,
                                 input logic [W-1:0] xd, input logic rdy);
        busDisable = dis;
        resToDl    = rtd;
        res        = r;
        dlIn       = d;
        rdReq      = rq;
        wrReq      = wq;
        extDin     = xd;
        extReady   = rdy;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mActive[i]  = 1'b0;
            mWr[i]      = 1'b0;
            mHold[i]    = 1'b0;
            mAge[i]     = 0;
            mRd[i]      = '1;
            mWrLatch[i] = '1;
        end
    endtask

    task automatic clearCounts();
        tickIdx = 0;
        for (int i = 0; i < 2; i++) begin
            cntOe[i]   = 0;
            cntRd[i]   = 0;
            cntWr[i]   = 0;
            cntDone[i] = 0;
            doneAt[i]  = -1;
        end
    endtask

    // what each instance should show in the current cycle, plus strobe tallies
    task automatic checkAll();
        logic         en, inAccess, expOe, expRd, expWr, expDone;
        logic [W-1:0] base, expDl;
        en = !busDisable;
        for (int i = 0; i < 2; i++) begin
            inAccess = mActive[i] && !mHold[i] && (mAge[i] >= 1);
            expOe    = en && mActive[i] && mWr[i];
            expRd    = en && inAccess && !mWr[i];
            expWr    = en && inAccess && mWr[i];
            expDone  = en && mActive[i] && mHold[i];
            base     = busDisable ? '1 : mRd[i];
            expDl    = resToDl ? (base & res) : base;
            checkOutput($sformatf("d%0d_oe", i),   32'(oe[i]),    32'(expOe));
            checkOutput($sformatf("d%0d_rd", i),   32'(rd[i]),    32'(expRd));
            checkOutput($sformatf("d%0d_wr", i),   32'(wr[i]),    32'(expWr));
            checkOutput($sformatf("d%0d_done", i), 32'(done[i]),  32'(expDone));
            checkOutput($sformatf("d%0d_busy", i), 32'(busy[i]),  32'(mActive[i]));
            checkOutput($sformatf("d%0d_dl", i),   32'(dlOut[i]), 32'(expDl));
            checkOutput($sformatf("d%0d_dout", i), 32'(dout[i]),  32'(mWrLatch[i]));
            if (oe[i] === 1'b1) cntOe[i]++;
            if (rd[i] === 1'b1) cntRd[i]++;
            if (wr[i] === 1'b1) cntWr[i]++;
            if (done[i] === 1'b1) begin
                cntDone[i]++;
                if (doneAt[i] < 0) doneAt[i] = tickIdx;
            end
        end
    endtask

    // advance the model across one rising edge using the inputs held there
    task automatic modelEdge();
        for (int i = 0; i < 2; i++) begin
            if (!busDisable) begin
                if (!mActive[i]) begin
                    if (wrReq) begin
                        mActive[i] = 1'b1; mWr[i] = 1'b1; mHold[i] = 1'b0; mAge[i] = 0;
                        mWrLatch[i] = dlIn;
                    end else if (rdReq) begin
                        mActive[i] = 1'b1; mWr[i] = 1'b0; mHold[i] = 1'b0; mAge[i] = 0;
                    end
                end else if (mHold[i]) begin
                    mActive[i] = 1'b0;
                    mHold[i]   = 1'b0;
                end else if (mAge[i] >= waitOf(i) + 1 && extReady) begin
                    mHold[i] = 1'b1;
                    if (!mWr[i]) mRd[i] = extDin;
                end else begin
                    mAge[i]++;
                end
            end
        end
    endtask

    // one clock: check mid-low phase, step the model at the edge, return at negedge
    task automatic tick();
        #1;
        checkAll();
        @(posedge clk);
        modelEdge();
        tickIdx++;
        @(negedge clk);
    endtask

    task automatic runIdle(input int limit);
        int n = 0;
        while ((mActive[0] || mActive[1]) && n < limit) begin
            tick();
            n++;
        end
        checkOutput("idle_bound", 32'(n >= limit), 32'(0));
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(0, 0, '0, '0, 0, 0, '0, 1);
        modelReset();
        clearCounts();

        // reset state
        @(negedge clk);
        #1;
        checkAll();
        checkOutput("rst_dl", 32'(dlOut[0]), 32'h0000_00FF);
        @(negedge clk);
        rstN = 1'b1;

        // idle pull-down merge
        applyStimulus(0, 1, 8'h3C, '0, 0, 0, '0, 1);
        #1;
        checkOutput("idle_merge0", 32'(dlOut[0]), 32'h3C);
        checkOutput("idle_merge1", 32'(dlOut[1]), 32'h3C);
        tick();

        // minimal read
        clearCounts();
        applyStimulus(0, 0, '0, '0, 1, 0, 8'hA5, 1);
        tick();
        applyStimulus(0, 0, '0, '0, 0, 0, 8'hA5, 1);
        runIdle(20);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("rd_strobes%0d", i), 32'(cntRd[i]), 32'(waitOf(i) + 1));
            checkOutput($sformatf("rd_done_at%0d", i), 32'(doneAt[i]), 32'(3 + waitOf(i)));
            checkOutput($sformatf("rd_dl%0d", i), 32'(dlOut[i]), 32'hA5);
        end
        applyStimulus(0, 1, 8'h0F, '0, 0, 0, 8'hA5, 1);
        #1;
        checkOutput("rd_merge0", 32'(dlOut[0]), 32'h05);
        checkOutput("rd_merge1", 32'(dlOut[1]), 32'h05);
        tick();

        // write: data captured at request, later dl_in changes are ignored
        clearCounts();
        applyStimulus(0, 0, '0, 8'h5A, 0, 1, '0, 1);
        tick();
        applyStimulus(0, 0, '0, 8'h00, 0, 0, '0, 1);
        runIdle(20);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("wr_oe_len%0d", i), 32'(cntOe[i]), 32'(waitOf(i) + 3));
            checkOutput($sformatf("wr_strobes%0d", i), 32'(cntWr[i]), 32'(waitOf(i) + 1));
            checkOutput($sformatf("wr_dout%0d", i), 32'(dout[i]), 32'h5A);
        end

        // ready stall: four not-ready access cycles, capture only on ready
        clearCounts();
        applyStimulus(0, 0, '0, '0, 1, 0, 8'h11, 0);
        tick();
        applyStimulus(0, 0, '0, '0, 0, 0, 8'h11, 0);
        repeat (5) tick();
        applyStimulus(0, 0, '0, '0, 0, 0, 8'h77, 1);
        runIdle(20);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("stall_rd%0d", i), 32'(cntRd[i]), 32'd5);
            checkOutput($sformatf("stall_dl%0d", i), 32'(dlOut[i]), 32'h77);
        end

        // simultaneous requests: write wins, extra read while busy is dropped
        clearCounts();
        applyStimulus(0, 0, '0, 8'hC3, 1, 1, 8'h99, 1);
        tick();
        applyStimulus(0, 0, '0, 8'h00, 1, 0, 8'h99, 1);
        tick();
        applyStimulus(0, 0, '0, 8'h00, 0, 0, 8'h99, 1);
        runIdle(20);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("both_rd%0d", i), 32'(cntRd[i]), 32'd0);
            checkOutput($sformatf("both_wr%0d", i), 32'(cntWr[i]), 32'(waitOf(i) + 1));
            checkOutput($sformatf("both_done%0d", i), 32'(cntDone[i]), 32'd1);
            checkOutput($sformatf("both_dout%0d", i), 32'(dout[i]), 32'hC3);
        end

        // bus released for three cycles in the middle of access
        clearCounts();
        applyStimulus(0, 0, '0, '0, 1, 0, 8'h3E, 1);
        tick();
        applyStimulus(0, 0, '0, '0, 0, 0, 8'h3E, 1);
        tick();
        applyStimulus(1, 0, '0, '0, 1, 1, 8'h3E, 1);
        #1;
        checkOutput("dis_dl0", 32'(dlOut[0]), 32'hFF);
        checkOutput("dis_rd0", 32'(rd[0]), 32'd0);
        repeat (3) tick();
        applyStimulus(0, 0, '0, '0, 0, 0, 8'h3E, 1);
        runIdle(20);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("dis_done%0d", i), 32'(cntDone[i]), 32'd1);
            checkOutput($sformatf("dis_strobes%0d", i), 32'(cntRd[i]), 32'(waitOf(i) + 1));
            checkOutput($sformatf("dis_dl_after%0d", i), 32'(dlOut[i]), 32'h3E);
        end

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 7) == 0, 1'($urandom), W'($urandom), W'($urandom),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, W'($urandom),
                          $urandom_range(0, 3) != 0);
            tick();
        end
        applyStimulus(0, 0, '0, '0, 0, 0, '0, 1);
        runIdle(40);

        // asynchronous reset in the middle of an access
        applyStimulus(0, 0, '0, '0, 1, 0, 8'h42, 0);
        tick();
        applyStimulus(0, 0, '0, '0, 0, 0, 8'h42, 0);
        repeat (2) tick();
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("midrst_dl", 32'(dlOut[0]), 32'hFF);
        checkOutput("midrst_busy", 32'(busy[1]), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(0, 0, '0, '0, 0, 0, '0, 1);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
